// File: rtl/rs_age_multi.sv
// rs_age_multi -- reservation station with DEPTH generic entries, CDB_N wakeup
// ports and oldest-ready-first issue chosen by an age matrix.
//
// Ports
//   clock_i / reset_i       clock, synchronous active-high reset
//   flush_i                 squash every entry (reset has priority)
//   dispatch_*              renamed op offered by rename; ready while any entry free
//   cdb_valid_i / cdb_tag_i CDB_N result broadcasts, port 0 in the LSBs
//   issue_*                 oldest ready entry, handshake frees it
//   count_o                 number of occupied entries
//
// Build option
//   RS_WAKEUP_BYPASS_EN     when defined, entry readiness also includes this
//                           cycle's CDB matches (0-cycle wakeup-to-issue).
//                           Undefined: readiness comes from registered bits only.

module rs_age_multi #(
  parameter  int DEPTH     = 8,
  parameter  int TAG_W     = 6,
  parameter  int CDB_N     = 2,
  parameter  int PAYLOAD_W = 64,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   dispatch_valid_i,
  output logic                   dispatch_ready_o,
  input  logic [1:0]             dispatch_src_used_i,
  input  logic [1:0]             dispatch_src_rdy_i,
  input  logic [2*TAG_W-1:0]     dispatch_src_tag_i,
  input  logic [PAYLOAD_W-1:0]   dispatch_payload_i,
  input  logic [CDB_N-1:0]       cdb_valid_i,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [PAYLOAD_W-1:0]   issue_payload_o,
  output logic [IDX_W-1:0]       issue_idx_o,
  output logic [IDX_W:0]         count_o
);

  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rdy0_q, rdy0_d;
  logic [DEPTH-1:0]     rdy1_q, rdy1_d;
  logic [TAG_W-1:0]     tag0_q [DEPTH];
  logic [TAG_W-1:0]     tag0_d [DEPTH];
  logic [TAG_W-1:0]     tag1_q [DEPTH];
  logic [TAG_W-1:0]     tag1_d [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d  [DEPTH];
  // older_q[i][j] = 1 : entry i was dispatched before entry j
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [DEPTH-1:0]     older_d [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;

  logic [DEPTH-1:0] hit0, hit1;
  logic             disp_hit0, disp_hit1;
  logic [DEPTH-1:0] entry_rdy;
  logic [DEPTH-1:0] blocked;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic [PAYLOAD_W-1:0] sel_pay;
  logic [IDX_W-1:0] free_idx;
  logic             dispatch_fire;
  logic             issue_fire;

  function automatic logic cdb_hit(input logic [CDB_N-1:0]       v,
                                   input logic [CDB_N*TAG_W-1:0] tags,
                                   input logic [TAG_W-1:0]       tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_N; p++) begin
      if (v[p] && (tags[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0[i] = cdb_hit(cdb_valid_i, cdb_tag_i, tag0_q[i]);
      hit1[i] = cdb_hit(cdb_valid_i, cdb_tag_i, tag1_q[i]);
    end
    disp_hit0 = cdb_hit(cdb_valid_i, cdb_tag_i, dispatch_src_tag_i[TAG_W-1:0]);
    disp_hit1 = cdb_hit(cdb_valid_i, cdb_tag_i, dispatch_src_tag_i[2*TAG_W-1:TAG_W]);
  end

  // Unused sources have their ready bit forced at dispatch, so a stray tag
  // match on them changes nothing.
`ifdef RS_WAKEUP_BYPASS_EN
  assign entry_rdy = valid_q & (rdy0_q | hit0) & (rdy1_q | hit1);
`else
  assign entry_rdy = valid_q & rdy0_q & rdy1_q;
`endif

  // Winner: ready entry with no older ready entry. Valid entries are totally
  // ordered by the matrix, so exactly one grant exists when any is ready.
  always_comb begin
    blocked = '0;
    grant   = '0;
    sel_idx = '0;
    sel_pay = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (entry_rdy[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
      grant[i] = entry_rdy[i] & ~blocked[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_idx = sel_idx | IDX_W'(i);
        sel_pay = sel_pay | pay_q[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign dispatch_ready_o = ~&valid_q;
  assign dispatch_fire    = dispatch_valid_i & dispatch_ready_o;
  assign issue_valid_o    = |entry_rdy;
  assign issue_fire       = issue_valid_o & issue_ready_i;
  assign issue_idx_o      = sel_idx;
  assign issue_payload_o  = sel_pay;
  assign count_o          = count_q;

  always_comb begin
    valid_d = valid_q;
    rdy0_d  = rdy0_q;
    rdy1_d  = rdy1_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      tag0_d[i]  = tag0_q[i];
      tag1_d[i]  = tag1_q[i];
      pay_d[i]   = pay_q[i];
      older_d[i] = older_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        rdy0_d[i] = rdy0_q[i] | hit0[i];
        rdy1_d[i] = rdy1_q[i] | hit1[i];
      end
    end

    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
      for (int j = 0; j < DEPTH; j++) older_d[j][sel_idx] = 1'b0;
    end

    // free_idx is invalid at cycle start, so it never collides with sel_idx.
    if (dispatch_fire) begin
      valid_d[free_idx] = 1'b1;
      rdy0_d[free_idx]  = ~dispatch_src_used_i[0] | dispatch_src_rdy_i[0] | disp_hit0;
      rdy1_d[free_idx]  = ~dispatch_src_used_i[1] | dispatch_src_rdy_i[1] | disp_hit1;
      tag0_d[free_idx]  = dispatch_src_tag_i[TAG_W-1:0];
      tag1_d[free_idx]  = dispatch_src_tag_i[2*TAG_W-1:TAG_W];
      pay_d[free_idx]   = dispatch_payload_i;
      for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = valid_q[j];
      older_d[free_idx] = '0;
    end

    if (dispatch_fire && !issue_fire) count_d = count_q + CNT_W'(1);
    else if (!dispatch_fire && issue_fire) count_d = count_q - CNT_W'(1);

    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      rdy0_q  <= '0;
      rdy1_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag0_q[i]  <= '0;
        tag1_q[i]  <= '0;
        pay_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag0_q[i]  <= tag0_d[i];
        tag1_q[i]  <= tag1_d[i];
        pay_q[i]   <= pay_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_age_multi.sv
// Testbench for rs_age_multi: directed vector table, hand-written corner
// sequences and a randomized run against a sequence-number reference model.
module tb_rs_age_multi;

`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, dispatch_valid, dispatch_ready;
  logic [1:0]  dispatch_src_used, dispatch_src_rdy;
  logic [11:0] dispatch_src_tag;
  logic [63:0] dispatch_payload;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        issue_valid, issue_ready;
  logic [63:0] issue_payload;
  logic [2:0]  issue_idx;
  logic [3:0]  count;

  always #5 clock = ~clock;

  rs_age_multi dut (
    .clock_i(clock), .reset_i(reset), .flush_i(flush),
    .dispatch_valid_i(dispatch_valid), .dispatch_ready_o(dispatch_ready),
    .dispatch_src_used_i(dispatch_src_used), .dispatch_src_rdy_i(dispatch_src_rdy),
    .dispatch_src_tag_i(dispatch_src_tag), .dispatch_payload_i(dispatch_payload),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_payload_o(issue_payload), .issue_idx_o(issue_idx), .count_o(count)
  );

  typedef struct {
    logic rst, fl, dv;
    logic [1:0] used, srdy;
    logic [5:0] t0, t1;
    logic [63:0] pay;
    logic [1:0] cv;
    logic [5:0] c0, c1;
    logic ir;
  } in_t;

  typedef struct {
    in_t in;
    logic e_iv;
    logic [2:0] e_idx;
    logic [3:0] e_cnt;
    logic [63:0] e_pay;
  } row_t;

  int n_err = 0;
  int n_chk = 0;
  in_t cur;

  // Reference model: slot contents plus a dispatch sequence number; the
  // oldest ready op is simply the one with the smallest sequence number.
  bit m_v[8], m_r0[8], m_r1[8];
  logic [5:0] m_t0[8], m_t1[8];
  logic [63:0] m_p[8];
  int m_seq[8];
  int seq_ctr = 0;
  bit x_iv, x_dr;
  int x_idx, x_cnt;
  logic [63:0] x_pay;

  function automatic in_t idle(bit ir);
    in_t x;
    x.rst = 0; x.fl = 0; x.dv = 0; x.used = 0; x.srdy = 0; x.t0 = 0; x.t1 = 0;
    x.pay = 0; x.cv = 0; x.c0 = 0; x.c1 = 0; x.ir = ir;
    return x;
  endfunction

  function automatic in_t disp(logic [1:0] used, logic [1:0] srdy, logic [5:0] t0,
                               logic [5:0] t1, logic [63:0] pay, bit ir);
    in_t x;
    x = idle(ir);
    x.dv = 1; x.used = used; x.srdy = srdy; x.t0 = t0; x.t1 = t1; x.pay = pay;
    return x;
  endfunction

  function automatic in_t bcast(logic [1:0] cv, logic [5:0] c0, logic [5:0] c1, bit ir);
    in_t x;
    x = idle(ir);
    x.cv = cv; x.c0 = c0; x.c1 = c1;
    return x;
  endfunction

  function automatic row_t mk(in_t in, bit iv, int idx, int cnt, logic [63:0] pay);
    row_t r;
    r.in = in; r.e_iv = iv; r.e_idx = 3'(idx); r.e_cnt = 4'(cnt); r.e_pay = pay;
    return r;
  endfunction

  function automatic bit hit(logic [5:0] tag);
    return (cur.cv[0] && cur.c0 == tag) || (cur.cv[1] && cur.c1 == tag);
  endfunction

  function automatic void model_eval();
    int best;
    bit rdy;
    best = -1;
    x_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_v[i]) x_cnt++;
      rdy = m_v[i] && (m_r0[i] || (BYP && hit(m_t0[i]))) && (m_r1[i] || (BYP && hit(m_t1[i])));
      if (rdy && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    end
    x_dr  = (x_cnt < 8);
    x_iv  = (best >= 0);
    x_idx = x_iv ? best : 0;
    x_pay = x_iv ? m_p[best] : 64'd0;
  endfunction

  function automatic void model_update();
    int fr;
    if (cur.rst || cur.fl) begin
      for (int i = 0; i < 8; i++) m_v[i] = 0;
      return;
    end
    fr = -1;
    for (int i = 7; i >= 0; i--) if (!m_v[i]) fr = i;
    for (int i = 0; i < 8; i++) begin
      if (m_v[i]) begin
        m_r0[i] = m_r0[i] | hit(m_t0[i]);
        m_r1[i] = m_r1[i] | hit(m_t1[i]);
      end
    end
    if (x_iv && cur.ir) m_v[x_idx] = 0;
    if (cur.dv && x_dr) begin
      m_v[fr]   = 1;
      m_r0[fr]  = !cur.used[0] || cur.srdy[0] || hit(cur.t0);
      m_r1[fr]  = !cur.used[1] || cur.srdy[1] || hit(cur.t1);
      m_t0[fr]  = cur.t0;
      m_t1[fr]  = cur.t1;
      m_p[fr]   = cur.pay;
      m_seq[fr] = seq_ctr++;
    end
  endfunction

  task automatic apply(input in_t in);
    @(negedge clock);
    cur = in;
    reset = in.rst; flush = in.fl; dispatch_valid = in.dv;
    dispatch_src_used = in.used; dispatch_src_rdy = in.srdy;
    dispatch_src_tag = {in.t1, in.t0}; dispatch_payload = in.pay;
    cdb_valid = in.cv; cdb_tag = {in.c1, in.c0}; issue_ready = in.ir;
    #1;
    model_eval();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    in_t r;
    r = idle(0);
    r.rst = 1;
    apply(r); model_update();
    apply(r); model_update();
  endtask

  row_t tbl[28];
  in_t  tmp;

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 0; m_r0[i] = 0; m_r1[i] = 0; m_t0[i] = 0; m_t1[i] = 0; m_p[i] = 0; m_seq[i] = 0;
    end

    tbl[0]  = mk(idle(0), 0, 0, 0, 0);
    tbl[1]  = mk(disp(2'b11, 2'b11, 0, 0, 64'hA1, 1), 0, 0, 0, 0);
    tbl[2]  = mk(idle(1), 1, 0, 1, 64'hA1);
    tbl[3]  = mk(idle(0), 0, 0, 0, 0);
    tbl[4]  = mk(disp(2'b01, 2'b00, 3, 0, 64'hAA, 0), 0, 0, 0, 0);
    tbl[5]  = mk(disp(2'b01, 2'b00, 4, 0, 64'hBB, 0), 0, 0, 1, 0);
    tbl[6]  = mk(bcast(2'b01, 4, 0, 0), BYP, BYP ? 1 : 0, 2, BYP ? 64'hBB : 64'h0);
    tbl[7]  = mk(idle(1), 1, 1, 2, 64'hBB);
    tbl[8]  = mk(bcast(2'b01, 3, 0, 0), BYP, 0, 1, BYP ? 64'hAA : 64'h0);
    tbl[9]  = mk(idle(1), 1, 0, 1, 64'hAA);
    tbl[10] = mk(idle(0), 0, 0, 0, 0);
    tbl[11] = mk(disp(2'b01, 2'b00, 3, 0, 64'hA2, 0), 0, 0, 0, 0);
    tbl[12] = mk(disp(2'b01, 2'b00, 4, 0, 64'hB2, 0), 0, 0, 1, 0);
    tbl[13] = mk(bcast(2'b11, 3, 4, 0), BYP, 0, 2, BYP ? 64'hA2 : 64'h0);
    tbl[14] = mk(idle(1), 1, 0, 2, 64'hA2);
    tbl[15] = mk(idle(1), 1, 1, 1, 64'hB2);
    tbl[16] = mk(idle(0), 0, 0, 0, 0);
    tmp = disp(2'b11, 2'b10, 9, 0, 64'hC3, 1);
    tmp.cv = 2'b10; tmp.c1 = 9;
    tbl[17] = mk(tmp, 0, 0, 0, 0);
    tbl[18] = mk(idle(1), 1, 0, 1, 64'hC3);
    tbl[19] = mk(disp(2'b11, 2'b11, 0, 0, 64'hD4, 0), 0, 0, 0, 0);
    tbl[20] = mk(idle(0), 1, 0, 1, 64'hD4);
    tbl[21] = mk(idle(0), 1, 0, 1, 64'hD4);
    tbl[22] = mk(idle(1), 1, 0, 1, 64'hD4);
    tbl[23] = mk(idle(0), 0, 0, 0, 0);
    tbl[24] = mk(disp(2'b11, 2'b11, 0, 0, 64'hE5, 0), 0, 0, 0, 0);
    tbl[25] = mk(disp(2'b11, 2'b11, 0, 0, 64'hF6, 1), 1, 0, 1, 64'hE5);
    tbl[26] = mk(idle(1), 1, 1, 1, 64'hF6);
    tbl[27] = mk(idle(0), 0, 0, 0, 0);

    do_reset();

    for (int k = 0; k < 28; k++) begin
      apply(tbl[k].in);
      chk($sformatf("tbl%0d issue_valid", k), issue_valid, tbl[k].e_iv);
      chk($sformatf("tbl%0d issue_idx", k), issue_idx, tbl[k].e_idx);
      chk($sformatf("tbl%0d issue_payload", k), issue_payload, tbl[k].e_pay);
      chk($sformatf("tbl%0d count", k), count, tbl[k].e_cnt);
      chk($sformatf("tbl%0d dispatch_ready", k), dispatch_ready, 1);
      model_update();
    end

    // Fill all entries waiting on tag 5, then release them together.
    for (int i = 0; i < 8; i++) begin
      apply(disp(2'b01, 2'b00, 5, 0, 64'(100 + i), 1));
      chk("fill issue_valid", issue_valid, 0);
      chk("fill count", count, i);
      chk("fill dispatch_ready", dispatch_ready, 1);
      model_update();
    end
    apply(disp(2'b11, 2'b11, 0, 0, 64'hDEAD, 1));
    chk("full dispatch_ready", dispatch_ready, 0);
    chk("full count", count, 8);
    chk("full issue_valid", issue_valid, 0);
    model_update();
    apply(bcast(2'b01, 5, 0, 0));
    chk("full bcast issue_valid", issue_valid, BYP);
    chk("full bcast count", count, 8);
    model_update();
    for (int k = 0; k < 8; k++) begin
      apply(idle(1));
      chk("drain issue_valid", issue_valid, 1);
      chk("drain issue_idx", issue_idx, k);
      chk("drain payload", issue_payload, 64'(100 + k));
      chk("drain count", count, 8 - k);
      chk("drain dispatch_ready", dispatch_ready, k > 0);
      model_update();
    end
    apply(idle(0));
    chk("drained issue_valid", issue_valid, 0);
    chk("drained count", count, 0);
    model_update();

    // Flush with five occupied entries and a competing dispatch.
    for (int i = 0; i < 5; i++) begin
      apply(disp(2'b01, 2'b00, 6, 0, 64'(200 + i), 0));
      model_update();
    end
    tmp = disp(2'b11, 2'b11, 0, 0, 64'h99, 1);
    tmp.fl = 1; tmp.cv = 2'b01; tmp.c0 = 6;
    apply(tmp);
    chk("preflush count", count, 5);
    model_update();
    apply(idle(1));
    chk("flush count", count, 0);
    chk("flush issue_valid", issue_valid, 0);
    chk("flush dispatch_ready", dispatch_ready, 1);
    model_update();
    apply(disp(2'b11, 2'b11, 0, 0, 64'h77, 0));
    model_update();
    apply(idle(1));
    chk("postflush issue_idx", issue_idx, 0);
    chk("postflush payload", issue_payload, 64'h77);
    model_update();

    // Broadcast-to-issue latency.
    apply(disp(2'b10, 2'b00, 0, 7, 64'h55, 0));
    model_update();
    apply(idle(0));
    chk("byp wait issue_valid", issue_valid, 0);
    model_update();
    apply(bcast(2'b10, 0, 7, 0));
    chk("byp bcast issue_valid", issue_valid, BYP);
    model_update();
    apply(idle(1));
    chk("byp after issue_valid", issue_valid, 1);
    chk("byp after payload", issue_payload, 64'h55);
    model_update();
    apply(idle(0));
    chk("byp done issue_valid", issue_valid, 0);
    model_update();

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tmp.rst  = ($urandom_range(0, 255) == 0);
      tmp.fl   = ($urandom_range(0, 99) == 0);
      tmp.dv   = ($urandom_range(0, 9) < 7);
      tmp.used = 2'($urandom);
      tmp.srdy = 2'($urandom);
      tmp.t0   = 6'($urandom_range(0, 7));
      tmp.t1   = 6'($urandom_range(0, 7));
      tmp.pay  = {$urandom, $urandom};
      tmp.cv   = 2'($urandom);
      tmp.c0   = 6'($urandom_range(0, 7));
      tmp.c1   = 6'($urandom_range(0, 7));
      tmp.ir   = ($urandom_range(0, 9) < 6);
      apply(tmp);
      chk("rnd issue_valid", issue_valid, x_iv);
      chk("rnd issue_idx", issue_idx, x_idx);
      chk("rnd issue_payload", issue_payload, x_pay);
      chk("rnd count", count, x_cnt);
      chk("rnd dispatch_ready", dispatch_ready, x_dr);
      model_update();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
